lsu_dmem_ctrl: RTL and testbench

Load/store unit sitting directly upstream of the data-memory wrapper (dram_top) in the MEM stage of the rv32i pipeline. It accepts one load/store per instruction from the pipeline and stalls the pipeline while the access is in flight. It translates byte addresses into 8-bit word addresses, byte masks and lane-replicated write data for the memory. On loads, it waits for the memory's registered valid, then extracts and sign/zero-extends the requested byte or halfword.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_load_align.sv | 27 ++
 rtl/lsu_dmem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and lane/mask helpers for the LSU data-memory path.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] MASK_WORD = 4'b1111;

  // Halfwords ignore addr[0] and words ignore addr[1:0]; codes 011/11x act as words.
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      F3_SB[1:0]: align_off = off;
      F3_SH[1:0]: align_off = {off[1], 1'b0};
      default:    align_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      F3_SB[1:0]: byte_mask = 4'b0001 << off;
      F3_SH[1:0]: byte_mask = off[1] ? 4'b1100 : 4'b0011;
      default:    byte_mask = MASK_WORD;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      F3_SB[1:0]: lane_data = {4{sd[7:0]}};
      F3_SH[1:0]: lane_data = {2{sd[15:0]}};
      F3_SW[1:0]: lane_data = sd;
      default:    lane_data = sd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load formatter: picks the byte/half lane from a memory word and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {24'h0, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {16'h0, half_sel};
      F3_LW:   data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// MEM-stage load/store unit in front of dram_top; stalls the pipeline per access.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned accesses into an lsu_err pulse.
//
// state  | meaning
// IDLE   | waiting for mem_read/mem_write; latches the request
// ACCESS | one-cycle dmem request strobe (store or load)
// WAIT   | load outstanding, counting towards TIMEOUT
// DONE   | result/err presented, stall released for one cycle
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT  = 8,
  parameter int ADDR_LSB = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        lsu_err,
  output logic        dmem_request,
  output logic        dmem_load,
  output logic        dmem_w_en,
  output logic [7:0]  dmem_address,
  output logic [31:0] dmem_write_data,
  output logic [3:0]  dmem_masking,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_read_data
);

  lsu_state_t  state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        store_q, store_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic        ld_q, ld_d;
  logic        wen_q, wen_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        op, trap;
  logic [1:0]  off_aln;
  logic [31:0] fmt_data;
  logic        unused_addr_hi;

  assign op             = mem_read | mem_write;
  assign off_aln        = align_off(funct3, addr[1:0]);
  assign unused_addr_hi = ^addr[31:ADDR_LSB+8];

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = op & (off_aln != addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  lsu_load_align u_align (
    .funct3_i (f3_q),
    .offset_i (off_q),
    .rdata_i  (dmem_read_data),
    .data_o   (fmt_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      store_q     <= 1'b0;
      cnt_q       <= 4'd0;
      load_data_q <= 32'h0;
      err_q       <= 1'b0;
      req_q       <= 1'b0;
      ld_q        <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 32'h0;
      mask_q      <= 4'h0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      store_q     <= store_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
      req_q       <= req_d;
      ld_q        <= ld_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    off_d       = off_q;
    store_d     = store_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    err_d       = 1'b0;
    req_d       = 1'b0;
    ld_d        = 1'b0;
    wen_d       = 1'b0;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        stall = op;
        if (trap) begin
          state_d     = DONE;
          err_d       = 1'b1;
          load_data_d = 32'h0;
        end else if (op) begin
          // A simultaneous read+write is issued as the store.
          state_d = ACCESS;
          f3_d    = funct3;
          off_d   = off_aln;
          store_d = mem_write;
          addr_d  = addr[ADDR_LSB+7:ADDR_LSB];
          wdata_d = lane_data(funct3, store_data);
          mask_d  = byte_mask(funct3, off_aln);
          req_d   = 1'b1;
          wen_d   = mem_write;
          ld_d    = ~mem_write;
        end
      end
      ACCESS: begin
        stall   = 1'b1;
        cnt_d   = 4'd0;
        state_d = store_q ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (dmem_valid) begin
          load_data_d = fmt_data;
          state_d     = DONE;
        end else if (cnt_q == 4'(TIMEOUT - 1)) begin
          load_data_d = 32'h0;
          err_d       = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign load_data       = load_data_q;
  assign lsu_err         = err_q;
  assign dmem_request    = req_q;
  assign dmem_load       = ld_q;
  assign dmem_w_en       = wen_q;
  assign dmem_address    = addr_q;
  assign dmem_write_data = wdata_q;
  assign dmem_masking    = mask_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl: directed cases plus random loads/stores vs a byte-level memory model.
module tb_lsu_dmem_ctrl;
  import lsu_pkg::*;

  localparam int TO   = 8;
  localparam int ALSB = 2;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk, rst, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, lsu_err, dmem_request, dmem_load, dmem_w_en, dmem_valid;
  logic [31:0] load_data, dmem_write_data, dmem_read_data;
  logic [7:0]  dmem_address;
  logic [3:0]  dmem_masking;

  int total = 0;
  int bad   = 0;
  logic [7:0]  dram  [1024];
  logic [7:0]  ref_m [1024];
  logic [31:0] exp_ld;

  lsu_dmem_ctrl #(.TIMEOUT(TO), .ADDR_LSB(ALSB)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .funct3          (funct3),
    .addr            (addr),
    .store_data      (store_data),
    .stall           (stall),
    .load_data       (load_data),
    .lsu_err         (lsu_err),
    .dmem_request    (dmem_request),
    .dmem_load       (dmem_load),
    .dmem_w_en       (dmem_w_en),
    .dmem_address    (dmem_address),
    .dmem_write_data (dmem_write_data),
    .dmem_masking    (dmem_masking),
    .dmem_valid      (dmem_valid),
    .dmem_read_data  (dmem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=expired exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic put_word(input int waddr, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      dram[waddr*4+i]  = w[8*i +: 8];
      ref_m[waddr*4+i] = w[8*i +: 8];
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_strobes"}, {dmem_request, dmem_load, dmem_w_en}, 0);
    chk({tag, "_address"}, dmem_address, 0);
    chk({tag, "_wdata"}, dmem_write_data, 0);
    chk({tag, "_mask"}, dmem_masking, 0);
    chk({tag, "_load_data"}, load_data, 0);
    chk({tag, "_err"}, lsu_err, 0);
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input int lat);
    int n, off, base, exp_stall, stall_cnt, req_cnt, err_cnt, k;
    bit st, mis, trap, tmo, done;
    logic [31:0] exp_wd, rd_word, v;
    logic [3:0]  exp_mask;
    logic [7:0]  exp_addr, b;
    logic [15:0] h;

    st   = wr;
    n    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = (n == 1) ? int'(a[1:0]) : (n == 2) ? int'(a[1]) * 2 : 0;
    mis  = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    trap = mis && TRAP_EN;
    tmo  = !st && !trap && (lat > TO);
    exp_addr = 8'((a >> ALSB) & 32'hFF);
    base     = int'(exp_addr) * 4;
    exp_mask = 4'(((1 << n) - 1) << off);
    for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = sd[8*(l % n) +: 8];
    exp_stall = trap ? 1 : st ? 2 : 2 + ((lat > TO) ? TO : lat);

    if (trap || tmo) begin
      exp_ld = 32'h0;
    end else if (st) begin
      for (int i = 0; i < n; i++) ref_m[base+off+i] = sd[8*i +: 8];
    end else begin
      if (n == 4) begin
        v = {ref_m[base+3], ref_m[base+2], ref_m[base+1], ref_m[base]};
      end else if (n == 2) begin
        h = {ref_m[base+off+1], ref_m[base+off]};
        v = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      end else begin
        b = ref_m[base+off];
        v = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      end
      exp_ld = v;
    end

    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    stall_cnt = 0; req_cnt = 0; err_cnt = 0; k = -1; done = 0; rd_word = 32'h0;
    for (int cyc = 0; cyc < 3*TO + 10 && !done; cyc++) begin
      #1;
      if (lsu_err) err_cnt++;
      if (stall) stall_cnt++;
      else done = 1;
      if (dmem_request) begin
        req_cnt++;
        chk("access_address", dmem_address, exp_addr);
        chk("access_mask", dmem_masking, exp_mask);
        chk("access_w_en", dmem_w_en, st);
        chk("access_load", dmem_load, !st);
        if (st) begin
          chk("access_wdata", dmem_write_data, exp_wd);
          for (int l = 0; l < 4; l++)
            if (dmem_masking[l]) dram[int'(dmem_address)*4+l] = dmem_write_data[8*l +: 8];
        end else begin
          for (int l = 0; l < 4; l++) rd_word[8*l +: 8] = dram[int'(dmem_address)*4+l];
        end
        k = 0;
      end else if (k >= 0) begin
        k++;
      end
      dmem_valid     = (k > 0) && (k == lat) && !st;
      dmem_read_data = dmem_valid ? rd_word : $urandom;
      if (!done) @(negedge clk);
    end
    if (!done) chk("op_cycle_bound", 0, 1);
    chk("stall_cycles", stall_cnt, exp_stall);
    chk("request_cycles", req_cnt, trap ? 0 : 1);
    chk("err_pulses", err_cnt, (trap || tmo) ? 1 : 0);
    chk("done_load_data", load_data, exp_ld);
    chk("done_strobes", {dmem_request, dmem_load, dmem_w_en}, 0);
    mem_read = 0; mem_write = 0; dmem_valid = 0;
    @(negedge clk);
    #1;
    chk("idle_stall", stall, 0);
    chk("idle_err", lsu_err, 0);
    chk("idle_load_hold", load_data, exp_ld);
    @(negedge clk);
  endtask

  initial begin
    rst = 0; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; store_data = 0;
    dmem_valid = 0; dmem_read_data = 0; exp_ld = 0;
    for (int i = 0; i < 1024; i++) begin
      dram[i]  = 8'($urandom);
      ref_m[i] = dram[i];
    end
    repeat (3) @(negedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1;
    @(negedge clk);

    run_op(0, 1, F3_SB, 32'h0000_0013, 32'h1234_56AB, 1);
    put_word(8'h10, 32'h80FF_7F01);
    run_op(1, 0, F3_LB,  32'h0000_0043, 32'h0, 1);
    chk("lb_lane3", load_data, 32'hFFFF_FF80);
    run_op(1, 0, F3_LBU, 32'h0000_0043, 32'h0, 1);
    chk("lbu_lane3", load_data, 32'h0000_0080);
    put_word(0, 32'h9ABC_1234);
    run_op(1, 0, F3_LH,  32'h0000_0002, 32'h0, 1);
    chk("lh_upper", load_data, 32'hFFFF_9ABC);
    run_op(1, 0, F3_LHU, 32'h0000_0002, 32'h0, 1);
    chk("lhu_upper", load_data, 32'h0000_9ABC);
    run_op(1, 0, F3_LW, 32'h0000_0100, 32'h0, TO + 5);
    run_op(1, 1, F3_SW, 32'h0000_03FC, 32'hCAFE_F00D, 1);
    run_op(1, 0, F3_LW, 32'h0000_03FC, 32'h0, 1);
    chk("sw_readback", load_data, 32'hCAFE_F00D);
    run_op(1, 0, F3_LW, 32'h0000_0044, 32'h0, TO);
    run_op(1, 0, F3_LH, 32'h0000_0047, 32'h0, 2);
    run_op(0, 1, F3_SW, 32'h0000_0002, 32'h5555_AAAA, 1);
    run_op(1, 0, F3_LW, 32'hFFFF_F000, 32'h0, 1);

    // Reset in the middle of a load, then a stray valid while idle.
    mem_read = 1; funct3 = F3_LW; addr = 32'h44;
    repeat (3) @(negedge clk);
    #1;
    chk("midop_stall", stall, 1);
    rst = 0; mem_read = 0;
    exp_ld = 32'h0;
    #1;
    check_idle_zero("midop_reset");
    dmem_valid = 1; dmem_read_data = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    chk("late_valid_stall", stall, 0);
    chk("late_valid_load_data", load_data, 0);
    chk("late_valid_request", dmem_request, 0);
    dmem_valid = 0;
    @(negedge clk);

    for (int t = 0; t < 200; t++) begin
      int sel, p, lat;
      bit rd, wr;
      sel = $urandom_range(0, 3);
      rd  = (sel != 0);
      wr  = (sel == 0) || (sel == 2);
      p   = $urandom_range(0, 9);
      lat = (p < 6) ? 1 : (p < 8) ? $urandom_range(2, TO) : TO + 1 + $urandom_range(0, 3);
      if (($urandom & 1) == 1)
        run_op(rd, wr, 3'($urandom), $urandom, $urandom, lat);
      else
        run_op(rd, wr, 3'($urandom), $urandom & 32'h0000_0FFF, $urandom, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
